// File: rtl/game_sequencer.sv
// Game phase controller: button debounce, idle/run/dead sequencing,
// BCD score, high score and scroll speed.
module game_sequencer #(
   parameter int DEBOUNCE_TICKS = 3,
   parameter int DEAD_HOLDOFF   = 30,
   parameter int SPEED_INIT     = 1,
   parameter int SPEED_MAX      = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_button,
   input  logic        i_tick_60hz,
   input  logic        i_tick_20hz,
   input  logic        i_collision,
   output logic        o_game_start_pulse,
   output logic [1:0]  o_state,
   output logic        o_running,
   output logic [15:0] o_score,
   output logic [15:0] o_hiscore,
   output logic [2:0]  o_speed
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DEAD = 2'b10;

   localparam logic [2:0] DB_TICKS = 3'(DEBOUNCE_TICKS);
   localparam logic [5:0] HOLD_INI = 6'(DEAD_HOLDOFF);
   localparam logic [2:0] SP_INIT  = 3'(SPEED_INIT);
   localparam logic [2:0] SP_MAX   = 3'(SPEED_MAX);

   logic [1:0]  state_q, state_d;
   logic        pulse_q, pulse_d;
   logic [15:0] score_q, score_d;
   logic [15:0] hiscore_q, hiscore_d;
   logic [2:0]  speed_q, speed_d;
   logic [5:0]  holdoff_q, holdoff_d;
   logic        btn_lvl_q, btn_lvl_d;
   logic [2:0]  db_cnt_q, db_cnt_d;
   logic        press_q, press_d;
   logic        start;
   logic [15:0] score_inc;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign score_inc = bcd_inc(score_q);

   // Debounced level only moves after DEBOUNCE_TICKS differing frame samples.
   always_comb begin
      btn_lvl_d = btn_lvl_q;
      db_cnt_d  = db_cnt_q;
      press_d   = 1'b0;
      if (i_tick_60hz) begin
         if (i_button != btn_lvl_q) begin
            if (db_cnt_q + 3'd1 == DB_TICKS) begin
               btn_lvl_d = i_button;
               db_cnt_d  = 3'd0;
               press_d   = i_button;
            end else begin
               db_cnt_d = db_cnt_q + 3'd1;
            end
         end else begin
            db_cnt_d = 3'd0;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      hiscore_d = hiscore_q;
      speed_d   = speed_q;
      holdoff_d = holdoff_q;
      start     = press_q &&
                  ((state_q == ST_IDLE) ||
                   ((state_q == ST_DEAD) && (holdoff_q == 6'd0)));
      pulse_d   = start;
      unique case (state_q)
         ST_IDLE: ;
         ST_RUN: begin
            // The collision latch still holds the last death during the pulse.
            if (i_collision && !pulse_q) begin
               state_d   = ST_DEAD;
               holdoff_d = HOLD_INI;
               if (score_q > hiscore_q) hiscore_d = score_q;
            end else if (i_tick_20hz && (score_q != 16'h9999)) begin
               score_d = score_inc;
               if ((score_inc[7:0] == 8'h00) && (speed_q != SP_MAX))
                  speed_d = speed_q + 3'd1;
            end
         end
         ST_DEAD: begin
            if (i_tick_60hz && (holdoff_q != 6'd0))
               holdoff_d = holdoff_q - 6'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (start) begin
         state_d = ST_RUN;
         score_d = 16'h0000;
         speed_d = SP_INIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pulse_q   <= 1'b0;
         score_q   <= 16'h0000;
         hiscore_q <= 16'h0000;
         speed_q   <= SP_INIT;
         holdoff_q <= 6'd0;
         btn_lvl_q <= 1'b0;
         db_cnt_q  <= 3'd0;
         press_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pulse_q   <= pulse_d;
         score_q   <= score_d;
         hiscore_q <= hiscore_d;
         speed_q   <= speed_d;
         holdoff_q <= holdoff_d;
         btn_lvl_q <= btn_lvl_d;
         db_cnt_q  <= db_cnt_d;
         press_q   <= press_d;
      end
   end

   assign o_game_start_pulse = pulse_q;
   assign o_state            = state_q;
   assign o_running          = (state_q == ST_RUN);
   assign o_score            = score_q;
   assign o_hiscore          = hiscore_q;
   assign o_speed            = speed_q;

endmodule
